// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART transmitter and receiver.
// Baud divisors assume a 50 MHz system clock and 16x oversampling.
package uart_pkg;

    localparam int CLK_HZ     = 50_000_000;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 14;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Clocks per oversample tick: round(CLK_HZ / (16 * baud)).
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        logic [DIV_W-1:0] n;
        case (sel)
            3'd0:    n = 14'd10417;
            3'd1:    n = 14'd2604;
            3'd2:    n = 14'd651;
            3'd3:    n = 14'd326;
            3'd4:    n = 14'd163;
            3'd5:    n = 14'd81;
            3'd6:    n = 14'd54;
            default: n = 14'd27;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_receiver_baud_controller.sv
// baud_controller: one-cycle sample_ENABLE every N clocks, N chosen by baud_select.
// A rate change restarts the count so the first tick at the new rate is a full period.
module baud_controller
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [DIV_W-1:0] last;
    logic             changed;

    always_comb begin
        last          = baud_div(baud_select) - 14'd1;
        changed       = (sel_q != baud_select);
        sel_d         = baud_select;
        sample_ENABLE = 1'b0;
        cnt_d         = cnt_q + 14'd1;
        // >= keeps the counter bounded if the rate drops mid-count
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q >= last) begin
            cnt_d         = '0;
            sample_ENABLE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled 8E1 UART receive path.
// Delivers each byte with a one-cycle valid strobe and sticky parity/framing flags.
module uart_receiver
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    logic sample_ENABLE;

    baud_controller u_baud (
        .clk          (clk),
        .reset        (reset),
        .baud_select  (baud_select),
        .sample_ENABLE(sample_ENABLE)
    );

    logic [1:0]           sync_q, sync_d;
    logic                 rxs;
    rx_state_e            state_q, state_d;
    logic [3:0]           scnt_q, scnt_d;
    logic [2:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 mid;

    assign rxs = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], RxD};
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        // mid-bit instant for DATA/PARITY/STOP: 16 ticks after the previous one
        mid     = sample_ENABLE && (scnt_q == TICK_LAST);
        if (sample_ENABLE) begin
            scnt_d = scnt_q + 4'd1;
        end

        if (state_q != IDLE && !Rx_EN) begin
            state_d = IDLE;
            scnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    scnt_d = '0;
                    if (sample_ENABLE && !rxs && Rx_EN) begin
                        state_d = START;
                        bcnt_d  = '0;
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                START: begin
                    if (sample_ENABLE && scnt_q == TICK_MID) begin
                        scnt_d  = '0;
                        state_d = rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        par_d   = par_q ^ rxs;
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == BIT_LAST) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (mid) begin
                        perr_d  = par_q ^ rxs;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        ferr_d  = !rxs;
                        data_d  = shift_q;
                        valid_d = rxs && !perr_q;
                        state_d = IDLE;
                        scnt_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    scnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed 8E1 frames driven onto RxD at several rates,
// covering good frames, parity/framing errors, false start, abort and reset.
module tb_uart_receiver;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] baud_select = 3'd7;
    logic       Rx_EN = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int n_cmp = 0;
    int n_bad = 0;
    int vcnt = 0;
    int wide = 0;
    logic [7:0] last_data = 8'h00;
    bit prev_valid = 1'b0;
    bit ferr_seen = 1'b0;

    uart_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .baud_select(baud_select),
        .Rx_EN      (Rx_EN),
        .RxD        (RxD),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (Rx_VALID) begin
            vcnt++;
            last_data = Rx_DATA;
            if (prev_valid) wide++;
        end
        prev_valid = Rx_VALID;
        if (Rx_FERROR) ferr_seen = 1'b1;
    end

    task automatic drive_bit(input logic b, input int n);
        RxD = b;
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input int n);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(b[i], n);
        drive_bit((^b) ^ par_flip, n);
        drive_bit(stop, n);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (Rx_DATA !== 8'h00) begin
            n_bad++; $display("FAIL rst_data: got %h want 00", Rx_DATA);
        end
        n_cmp++;
        if (Rx_VALID !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid: got %b want 0", Rx_VALID);
        end
        n_cmp++;
        if (Rx_PERROR !== 1'b0 || Rx_FERROR !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flags: got p%b f%b want p0 f0", Rx_PERROR, Rx_FERROR);
        end
        reset = 1'b1;
        Rx_EN = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [4] = '{8'hAA, 8'h55, 8'hCC, 8'h89};
        int v0 = vcnt;
        baud_select = 3'd7;
        for (int i = 0; i < 4; i++) begin
            send_frame(bytes[i], 1'b0, 1'b1, 27);
            n_cmp++;
            if (last_data !== bytes[i] || vcnt != v0 + i + 1) begin
                n_bad++;
                $display("FAIL loop_byte%0d: got %h (%0d valids) want %h (%0d)",
                         i, last_data, vcnt - v0, bytes[i], i + 1);
            end
        end
        repeat (16) @(negedge clk);
        n_cmp++;
        if (vcnt - v0 != 4) begin
            n_bad++; $display("FAIL loop_count: got %0d want 4", vcnt - v0);
        end
        n_cmp++;
        if (Rx_PERROR !== 1'b0 || Rx_FERROR !== 1'b0) begin
            n_bad++;
            $display("FAIL loop_flags: got p%b f%b want p0 f0", Rx_PERROR, Rx_FERROR);
        end
    endtask

    task automatic test_false_start();
        int v0 = vcnt;
        RxD = 1'b0;
        repeat (3 * 27) @(negedge clk);
        RxD = 1'b1;
        repeat (20 * 27) @(negedge clk);
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++; $display("FAIL fs_state: got %0d want IDLE", dut.state_q);
        end
        n_cmp++;
        if (Rx_DATA !== 8'h89 || vcnt != v0) begin
            n_bad++;
            $display("FAIL fs_out: got %h (%0d valids) want 89 (0)", Rx_DATA, vcnt - v0);
        end
        n_cmp++;
        if (Rx_PERROR !== 1'b0 || Rx_FERROR !== 1'b0) begin
            n_bad++;
            $display("FAIL fs_flags: got p%b f%b want p0 f0", Rx_PERROR, Rx_FERROR);
        end
    endtask

    task automatic test_parity_error();
        int v0 = vcnt;
        send_frame(8'h01, 1'b1, 1'b1, 27);
        repeat (16) @(negedge clk);
        n_cmp++;
        if (Rx_PERROR !== 1'b1 || Rx_FERROR !== 1'b0) begin
            n_bad++;
            $display("FAIL par_flags: got p%b f%b want p1 f0", Rx_PERROR, Rx_FERROR);
        end
        n_cmp++;
        if (vcnt != v0) begin
            n_bad++; $display("FAIL par_valid: got %0d valids want 0", vcnt - v0);
        end
        n_cmp++;
        if (Rx_DATA !== 8'h01) begin
            n_bad++; $display("FAIL par_data: got %h want 01", Rx_DATA);
        end
    endtask

    task automatic test_framing_error();
        int v0 = vcnt;
        ferr_seen = 1'b0;
        send_frame(8'hF0, 1'b0, 1'b0, 27);
        RxD = 1'b1;
        repeat (20 * 27) @(negedge clk);
        n_cmp++;
        if (ferr_seen !== 1'b1) begin
            n_bad++; $display("FAIL frm_flag: got %b want 1", ferr_seen);
        end
        n_cmp++;
        if (vcnt != v0) begin
            n_bad++; $display("FAIL frm_valid: got %0d valids want 0", vcnt - v0);
        end
        n_cmp++;
        if (Rx_DATA !== 8'hF0 || Rx_PERROR !== 1'b0) begin
            n_bad++;
            $display("FAIL frm_data: got %h p%b want F0 p0", Rx_DATA, Rx_PERROR);
        end
    endtask

    task automatic test_abort();
        int v0 = vcnt;
        logic [7:0] b = 8'hA5;
        drive_bit(1'b0, 27);
        for (int i = 0; i < 4; i++) drive_bit(b[i], 27);
        RxD = b[4];
        repeat (8 * 27) @(negedge clk);
        Rx_EN = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++; $display("FAIL abort_state: got %0d want IDLE", dut.state_q);
        end
        RxD = 1'b1;
        repeat (7 * 16 * 27) @(negedge clk);
        Rx_EN = 1'b1;
        repeat (64) @(negedge clk);
        n_cmp++;
        if (vcnt != v0 || Rx_DATA !== 8'hF0) begin
            n_bad++;
            $display("FAIL abort_out: got %h (%0d valids) want F0 (0)", Rx_DATA, vcnt - v0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        drive_bit(1'b0, 27);
        drive_bit(1'b0, 27);
        drive_bit(1'b1, 27);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (Rx_DATA !== 8'h00 || Rx_VALID !== 1'b0 ||
            Rx_PERROR !== 1'b0 || Rx_FERROR !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_out: got %h v%b p%b f%b want 00 v0 p0 f0",
                     Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR);
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state_q);
        end
        @(negedge clk);
        reset = 1'b1;
        RxD = 1'b1;
        repeat (32 * 27) @(negedge clk);
        v0 = vcnt;
        send_frame(8'h7E, 1'b0, 1'b1, 27);
        n_cmp++;
        if (last_data !== 8'h7E || vcnt != v0 + 1) begin
            n_bad++;
            $display("FAIL rstmid_frame: got %h (%0d valids) want 7E (1)", last_data, vcnt - v0);
        end
    endtask

    task automatic test_divisors();
        int sel [6] = '{2, 3, 4, 5, 6, 7};
        int div [6] = '{651, 326, 163, 81, 54, 27};
        for (int k = 0; k < 6; k++) begin
            int c = 0;
            bit got = 1'b0;
            baud_select = 3'(sel[k]);
            for (int t = 0; t < 3 * div[k] && !got; t++) begin
                @(negedge clk);
                got = dut.u_baud.sample_ENABLE;
            end
            got = 1'b0;
            while (c < 3 * div[k] && !got) begin
                @(negedge clk);
                c++;
                got = dut.u_baud.sample_ENABLE;
            end
            n_cmp++;
            if (!got || c != div[k]) begin
                n_bad++;
                $display("FAIL div_sel%0d: got %0d clocks want %0d", sel[k], c, div[k]);
            end
        end
    endtask

    task automatic test_rate_sweep();
        int sel [3] = '{5, 6, 7};
        int div [3] = '{81, 54, 27};
        for (int k = 0; k < 3; k++) begin
            int v0;
            baud_select = 3'(sel[k]);
            repeat (32 * div[k]) @(negedge clk);
            v0 = vcnt;
            send_frame(8'h3C, 1'b0, 1'b1, div[k]);
            n_cmp++;
            if (last_data !== 8'h3C || vcnt != v0 + 1) begin
                n_bad++;
                $display("FAIL sweep_sel%0d: got %h (%0d valids) want 3C (1)",
                         sel[k], last_data, vcnt - v0);
            end
        end
        n_cmp++;
        if (wide != 0) begin
            n_bad++; $display("FAIL valid_width: got %0d wide pulses want 0", wide);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_false_start();
        test_parity_error();
        test_framing_error();
        test_abort();
        test_reset_mid_frame();
        test_divisors();
        test_rate_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: the receive end of the link driven by `uart_transmitter`. It recovers 11-bit frames from `RxD`: start 0, 8 data bits LSB first, even parity, stop 1. Each frame is presented as a byte with a one-cycle valid strobe and sticky parity/framing error flags. It shares the 50 MHz system clock and the `baud_select` encoding with the transmitter and oversamples at 16× the baud rate.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; documentation only, the divisors below assume it.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `baud_select`  in  3  rate: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
- `Rx_EN`  in  1  receiver enable; low forces IDLE.
- `RxD`  in  1  serial line, asynchronous, idle high.
- `Rx_DATA`  out  8  last received byte; reset 0.
- `Rx_VALID`  out  1  one-cycle pulse for a frame with no errors; reset 0.
- `Rx_PERROR`  out  1  parity error, sticky; reset 0.
- `Rx_FERROR`  out  1  framing error (stop bit sampled 0), sticky; reset 0.

## Operation
- **Input synchronisation:** `RxD` passes through a 2-FF synchronizer that resets to 1. All logic uses the synchronized value `rxs`.
- **Sampling:** `sample_ENABLE` pulses one cycle every N clocks. N is selected by `baud_select`: 10417, 2604, 651, 326, 163, 81, 54, 27.
- **Sample counter:** 4 bits, advances only on `sample_ENABLE`.
- **IDLE:**
  - Sample counter is held at 0.
  - A `sample_ENABLE` with `rxs`=0 and `Rx_EN`=1 moves to START.
  - Entering START clears `Rx_PERROR` and `Rx_FERROR`.
- **START:**
  - At the sample counter's 8th tick, `rxs`=0 moves to DATA and restarts the counter.
  - `rxs`=1 at that point is a false start: return to IDLE, flags stay cleared.
- **DATA:**
  - Sample `rxs` at tick 8 of each 16-tick bit and shift it in LSB first.
  - After 8 bits, move to PARITY.
- **PARITY:**
  - Sample at mid-bit.
  - Set `Rx_PERROR` if the XOR of the 8 data bits and the parity bit is 1.
  - Move to STOP.
- **STOP:**
  - Sample at mid-bit.
  - Stop bit = 0: set `Rx_FERROR`.
  - Load `Rx_DATA` with the shifted byte whether or not there is an error.
  - Pulse `Rx_VALID` only if both error flags are 0.
  - Go to IDLE immediately, without waiting out the rest of the stop bit, so back-to-back frames are accepted.
- **Rx_EN deasserted mid-frame:** abort to IDLE on the next clock. No `Rx_VALID`, `Rx_DATA` unchanged, flags unchanged.
- **baud_select changes:** valid only while IDLE. A change mid-frame gives undefined data but must not hang the FSM.
- **reset asserted:** async return to IDLE, all outputs to reset values, baud counter cleared.

## Timing
- **Bit period:** 16·N clocks; at 115200 this is 432 clocks (8.64 µs).
- **Start-edge to FSM:** 2 clocks of synchronizer delay plus up to N clocks of tick quantisation.
- **Frame latency:** `Rx_VALID` rises on the clock after the stop-bit mid-sample. That is about 10.5 bit periods after the start edge, ±1 tick.
- **Output timing:** `Rx_DATA`, `Rx_PERROR` and `Rx_FERROR` update on the same edge as `Rx_VALID`. They are stable until the next frame's START entry (flags) or STOP sample (data).
- **Rx_VALID:** exactly 1 cycle wide. There is no back-pressure; the consumer must capture the byte before the next frame ends.
- **Baud tolerance:** mid-bit sampling must tolerate ±3% baud mismatch.

## Structure
- **Shared package `uart_pkg`:**
  - baud divisor table indexed by `baud_select`;
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP;
  - constants DATA_BITS=8, OVERSAMPLE=16.
- **Sub-module `baud_controller`:**
  - inputs `clk`, `reset`, `baud_select`; output `sample_ENABLE`;
  - same instance type as the transmitter side;
  - counter clears when it reaches N−1 and whenever `baud_select` changes.
- **Receiver top:** synchronizer, FSM, sample counter, bit counter, shift register, parity accumulator.

## Test plan
- **Loopback pass:** `uart_transmitter` → `uart_receiver`, baud_select=7, send 0xAA, 0x55, 0xCC, 0x89 back to back. Required: four `Rx_VALID` pulses, `Rx_DATA` equal to each byte, both error flags 0.
- **Rate sweep:** baud_select 0–7 with byte 0x3C at each rate. Required: correct byte each time; measured bit period equals 16·N clocks ±N.
- **Parity error:** bench-driven frame 0x01 with parity bit 0. Required: `Rx_PERROR`=1, no `Rx_VALID`, `Rx_DATA`=0x01. The flag clears at the next start bit.
- **Framing error:** frame 0xF0 with correct parity and stop bit 0. Required: `Rx_FERROR`=1, no `Rx_VALID`.
- **False start:** 3-tick low glitch on idle `RxD`. Required: FSM returns to IDLE, no outputs change.
- **Abort and reset:**
  - `Rx_EN` deasserted during data bit 4. Required: IDLE, no `Rx_VALID`.
  - `reset` pulsed low mid-frame. Required: all outputs 0 immediately; the next full frame (0x7E) is received correctly.
